// File: rtl/code_length_checker.sv
// Keypad entry-length checker for the digital lock: tracks unlock/reprogram
// entry, counts digits per field and pulses valid_uc/valid_pc/len_err.
module code_length_checker #(
  parameter int unsigned KEY_W       = 4,
  parameter int unsigned LOCK_KEY    = 9,
  parameter int unsigned PROG_KEY    = 8,
  parameter int unsigned CLEAR_KEY   = 7,
  parameter int unsigned UC_MIN      = 4,
  parameter int unsigned UC_MAX      = 6,
  parameter int unsigned PC_LEN      = 6,
  parameter int unsigned PROG_FIELDS = 2,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic                                 hwclk,
  input  logic                                 rst,
  input  logic                                 key_valid,
  input  logic [KEY_W-1:0]                     key,
  input  logic                                 input_wrong,
  output logic                                 valid_uc,
  output logic                                 valid_pc,
  output logic                                 len_err,
  output logic [1:0]                           mode,
  output logic [$clog2(PROG_FIELDS+1)-1:0]     field_idx,
  output logic [CNT_W-1:0]                     digit_count
);

  localparam int unsigned FW = $clog2(PROG_FIELDS + 1);
  localparam int unsigned TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [KEY_W-1:0] LOCK_K  = KEY_W'(LOCK_KEY);
  localparam logic [KEY_W-1:0] PROG_K  = KEY_W'(PROG_KEY);
  localparam logic [KEY_W-1:0] CLEAR_K = KEY_W'(CLEAR_KEY);
  localparam logic [CNT_W-1:0] UC_MIN_C = CNT_W'(UC_MIN);
  localparam logic [CNT_W-1:0] UC_MAX_C = CNT_W'(UC_MAX);
  localparam logic [CNT_W-1:0] PC_LEN_C = CNT_W'(PC_LEN);
  localparam logic [FW-1:0]    LAST_F   = FW'(PROG_FIELDS);
  localparam logic [TW-1:0]    TMO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_LOCK = 2'd1,
    READ_PROG = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [FW-1:0]     field_q, field_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              uc_q, uc_d, pc_q, pc_d, err_q, err_d;

  logic is_lock, is_prog, is_clear, is_digit, in_entry, timeout_hit;
  logic count_sat, uc_ok, pc_ok;

  always_comb begin
    is_lock   = key_valid && (key == LOCK_K);
    is_prog   = key_valid && (key == PROG_K);
    is_clear  = key_valid && (key == CLEAR_K);
    is_digit  = key_valid && !is_lock && !is_prog && !is_clear;
    in_entry  = (state_q == READ_LOCK) || (state_q == READ_PROG);
    // Fires on the TIMEOUT_CYC-th cycle since entry or the last key strobe.
    timeout_hit = (TIMEOUT_CYC > 0) && in_entry && (timer_q == TMO_LAST);
    count_sat = (count_q == '1);
    uc_ok     = !count_sat && (count_q >= UC_MIN_C) && (count_q <= UC_MAX_C);
    pc_ok     = !count_sat && (count_q == PC_LEN_C);
  end

  always_comb begin
    state_d = state_q;
    field_d = field_q;
    count_d = count_q;
    timer_d = timer_q;
    uc_d    = 1'b0;
    pc_d    = 1'b0;
    err_d   = 1'b0;

    if ((TIMEOUT_CYC > 0) && in_entry) begin
      timer_d = key_valid ? '0 : timer_q + TW'(1);
    end

    if (input_wrong || is_clear || timeout_hit) begin
      err_d   = !input_wrong && !is_clear;
      state_d = IDLE;
      field_d = '0;
      count_d = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          timer_d = '0;
          if (is_lock) begin
            state_d = READ_LOCK;
            field_d = '0;
            count_d = '0;
          end else if (is_prog) begin
            state_d = READ_PROG;
            field_d = '0;
            count_d = '0;
          end
        end
        READ_LOCK: begin
          if (is_digit && !count_sat) begin
            count_d = count_q + CNT_W'(1);
          end else if (is_lock || is_prog) begin
            uc_d    = is_lock && uc_ok;
            err_d   = !(is_lock && uc_ok);
            state_d = IDLE;
            count_d = '0;
          end
        end
        READ_PROG: begin
          if (is_digit && !count_sat) begin
            count_d = count_q + CNT_W'(1);
          end else if (is_lock) begin
            count_d = '0;
          end else if (is_prog) begin
            count_d = '0;
            if (!((field_q == '0) ? uc_ok : pc_ok)) begin
              err_d   = 1'b1;
              state_d = IDLE;
              field_d = '0;
            end else if (field_q == LAST_F) begin
              pc_d    = 1'b1;
              state_d = IDLE;
              field_d = '0;
            end else begin
              field_d = field_q + FW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          field_d = '0;
          count_d = '0;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge hwclk) begin
    if (rst) begin
      state_q <= IDLE;
      field_q <= '0;
      count_q <= '0;
      timer_q <= '0;
      uc_q    <= 1'b0;
      pc_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      count_q <= count_d;
      timer_q <= timer_d;
      uc_q    <= uc_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  assign valid_uc    = uc_q;
  assign valid_pc    = pc_q;
  assign len_err     = err_q;
  assign mode        = state_q;
  assign field_idx   = field_q;
  assign digit_count = count_q;

endmodule
